pmod_16led_arb: RTL and testbench

Time-sharing arbiter for the 16-LED PMOD. It lets three requesters (for example a counter display, a status word and an alarm pattern) share the single `pmod_16led` output. Requesters are granted round-robin, and each grant lasts a minimum dwell period measured in prescaled ticks. An optional per-requester blink mode is applied to the granted pattern. The block sits between the pattern sources and the top-level PMOD pins.

---
 rtl/pmod_16led_arb_pkg.sv | 38 +++
 rtl/pmod_16led_arb_if.sv | 23 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/pmod_16led_arb.sv | 118 +++++++++++
 tb/tb_pmod_16led_arb.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pmod_16led_arb_pkg.sv
// Shared definitions for the PMOD 16-LED arbiter: FSM states, source count
// and the round-robin selection helper.
package pmod_16led_pkg;

  localparam int unsigned N_SRC = 3;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // First requester scanning last+1, last+2, last (mod N_SRC).
  function automatic pick_t rr_pick(input logic [N_SRC-1:0] req, input logic [1:0] last);
    pick_t       r;
    int unsigned t;
    logic [1:0]  c;
    r = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      t = (32'(last) + k) % N_SRC;
      c = 2'(t);
      if (!r.valid && req[c]) begin
        r.valid = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
    return N_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/pmod_16led_arb_if.sv
// Pattern-source / arbiter connection bundle for the PMOD 16-LED arbiter.
interface pmod_16led_arb_if;

  logic [pmod_16led_pkg::N_SRC-1:0] req;
  logic [15:0]                      pat0;
  logic [15:0]                      pat1;
  logic [15:0]                      pat2;
  logic [pmod_16led_pkg::N_SRC-1:0] blink;
  logic [pmod_16led_pkg::N_SRC-1:0] grant;
  logic                             busy;
  logic [15:0]                      pmod_16led;

  modport master (
    output req, pat0, pat1, pat2, blink,
    input  grant, busy, pmod_16led
  );

  modport slave (
    input  req, pat0, pat1, pat2, blink,
    output grant, busy, pmod_16led
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_CYC-1 counter with a one-cycle tick at terminal count
// and a synchronous clear.
module tick_prescaler #(
  parameter int unsigned TICK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pmod_16led_arb.sv
// Round-robin time-sharing arbiter for the 16-LED PMOD with minimum dwell
// and per-source blink masking.
module pmod_16led_arb
  import pmod_16led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned TICK_HZ = 2,
  parameter int unsigned DWELL   = 4
) (
  input  logic             clk,
  input  logic             rst,
  pmod_16led_arb_if.slave  bus,
  output logic             gpio0
);

  localparam int unsigned TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int unsigned DW       = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_V = DW'(DWELL);

  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              phase_q, phase_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [15:0]       led_q, led_d;
  logic              tick;
  logic              clr;
  pick_t             pick_any, pick_other;
  logic [15:0]       pat_sel;

  tick_prescaler #(
    .TICK_CYC(TICK_CYC)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .tick_o(tick)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    dwell_d    = dwell_q;
    phase_d    = phase_q;
    clr        = 1'b0;
    pick_any   = rr_pick(bus.req, last_q);
    // Owner is masked so a switch only happens toward a different source.
    pick_other = rr_pick(bus.req & ~onehot(last_q), last_q);

    unique case (state_q)
      IDLE: begin
        if (pick_any.valid) begin
          state_d = SHOW;
          last_d  = pick_any.idx;
          dwell_d = '0;
          phase_d = 1'b1;
          clr     = 1'b1;
        end
      end
      SHOW: begin
        if (!bus.req[last_q]) begin
          state_d = IDLE;
        end else if (dwell_q == DWELL_V && pick_other.valid) begin
          last_d  = pick_other.idx;
          dwell_d = '0;
          phase_d = 1'b1;
          clr     = 1'b1;
        end else if (tick) begin
          if (dwell_q != DWELL_V) begin
            dwell_d = dwell_q + DW'(1);
          end
          if (bus.blink[last_q]) begin
            phase_d = ~phase_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (last_d)
      2'd0:    pat_sel = bus.pat0;
      2'd1:    pat_sel = bus.pat1;
      default: pat_sel = bus.pat2;
    endcase

    // Outputs are built from next-state so grant, busy and LEDs move together.
    grant_d = (state_d == SHOW) ? onehot(last_d) : '0;
    busy_d  = (state_d == SHOW);
    led_d   = (state_d == SHOW && (phase_d || !bus.blink[last_d])) ? pat_sel : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      dwell_q <= '0;
      phase_q <= 1'b1;
      grant_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.pmod_16led = led_q;
  assign gpio0          = 1'b1;

endmodule

// File: tb/tb_pmod_16led_arb.sv
// Self-checking bench for pmod_16led_arb: directed scenarios plus random
// request/blink/pattern traffic against an ownership-age reference model.
module tb_pmod_16led_arb;

  localparam int TCYC = 4;
  localparam int DWL  = 2;

  logic clk = 1'b0;
  logic rst;
  logic gpio0;

  int n_tests = 0;
  int n_fail  = 0;

  pmod_16led_arb_if bus();

  pmod_16led_arb #(
    .CLK_HZ (8),
    .TICK_HZ(2),
    .DWELL  (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .gpio0(gpio0)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 idle), cycles since grant, blink flips.
  int          m_owner, m_last, m_age, m_flips;
  logic [2:0]  exp_grant;
  logic        exp_busy;
  logic [15:0] exp_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 2;
    m_age     = 0;
    m_flips   = 0;
    exp_grant = '0;
    exp_busy  = 1'b0;
    exp_led   = '0;
  endtask

  function automatic int first_req(input logic [2:0] r, input int last, input bit incl_last);
    int n;
    int idx;
    n = incl_last ? 3 : 2;
    for (int k = 1; k <= n; k++) begin
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] pat_of(input int i, input logic [15:0] p0,
                                         input logic [15:0] p1, input logic [15:0] p2);
    if (i == 0) return p0;
    if (i == 1) return p1;
    return p2;
  endfunction

  task automatic model_edge(input logic [2:0] r, input logic [2:0] b, input logic [15:0] p0,
                            input logic [15:0] p1, input logic [15:0] p2);
    int idx;
    if (m_owner < 0) begin
      idx = first_req(r, m_last, 1'b1);
      if (idx >= 0) begin
        m_owner = idx; m_last = idx; m_age = 0; m_flips = 0;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else begin
      idx = (m_age >= DWL * TCYC) ? first_req(r, m_last, 1'b0) : -1;
      if (idx >= 0) begin
        m_owner = idx; m_last = idx; m_age = 0; m_flips = 0;
      end else begin
        if ((m_age % TCYC) == TCYC - 1 && b[m_owner]) m_flips++;
        m_age++;
      end
    end
    exp_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    exp_busy  = (m_owner >= 0);
    if (m_owner >= 0 && ((m_flips % 2) == 0 || !b[m_owner]))
      exp_led = pat_of(m_owner, p0, p1, p2);
    else
      exp_led = '0;
  endtask

  task automatic step(input string tag);
    model_edge(bus.req, bus.blink, bus.pat0, bus.pat1, bus.pat2);
    @(posedge clk);
    #1;
    chk({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    chk({tag, ".led"}, 32'(bus.pmod_16led), 32'(exp_led));
  endtask

  logic [2:0]  g_hist [0:35];
  logic [15:0] l_hist [0:15];

  initial begin
    rst       = 1'b1;
    bus.req   = '0;
    bus.blink = '0;
    bus.pat0  = 16'h1111;
    bus.pat1  = 16'h2222;
    bus.pat2  = 16'h4444;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant", 32'(bus.grant), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.led", 32'(bus.pmod_16led), 32'd0);
    chk("gpio0", 32'(gpio0), 32'd1);
    rst = 1'b0;

    // Contention from reset: 001, 010, 100, 001 with 9-cycle grants.
    bus.req = 3'b111;
    for (int i = 0; i < 36; i++) begin
      step("rr");
      g_hist[i] = bus.grant;
    end
    chk("rr.first", 32'(g_hist[0]), 32'b001);
    chk("rr.end0", 32'(g_hist[8]), 32'b001);
    chk("rr.second", 32'(g_hist[9]), 32'b010);
    chk("rr.end1", 32'(g_hist[17]), 32'b010);
    chk("rr.third", 32'(g_hist[18]), 32'b100);
    chk("rr.end2", 32'(g_hist[26]), 32'b100);
    chk("rr.fourth", 32'(g_hist[27]), 32'b001);

    // Asynchronous reset mid-grant, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst.grant", 32'(bus.grant), 32'd0);
    chk("arst.busy", 32'(bus.busy), 32'd0);
    chk("arst.led", 32'(bus.pmod_16led), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("arst.rearb");
    chk("arst.src0", 32'(bus.grant), 32'b001);

    // Early drop: owner 0 falls at cycle 3, source 2 waiting.
    bus.req = 3'b101;
    repeat (3) step("drop");
    bus.req = 3'b100;
    step("drop.rel");
    chk("drop.idle", 32'(bus.grant), 32'd0);
    step("drop.next");
    chk("drop.src2", 32'(bus.grant), 32'b100);

    // Single source steady, then pattern change.
    bus.req  = 3'b010;
    bus.pat1 = 16'hA5A5;
    step("single.a");
    step("single.b");
    chk("single.grant", 32'(bus.grant), 32'b010);
    chk("single.led", 32'(bus.pmod_16led), 32'hA5A5);
    repeat (12) step("single.hold");
    bus.pat1 = 16'h0F0F;
    step("single.chg");
    chk("single.newpat", 32'(bus.pmod_16led), 32'h0F0F);

    // Blink on source 0: 4 on, 4 off, starting on the grant cycle.
    bus.req = 3'b000;
    repeat (2) step("blink.idle");
    bus.req   = 3'b001;
    bus.blink = 3'b001;
    bus.pat0  = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      step("blink");
      l_hist[i] = bus.pmod_16led;
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("blink.seq%0d", i), 32'(l_hist[i]), ((i / 4) % 2 == 0) ? 32'hFFFF : 32'h0);
    end

    // Owner drop on the cycle of the second tick, other source requesting.
    bus.req   = 3'b000;
    bus.blink = 3'b000;
    repeat (2) step("exp.idle");
    bus.req = 3'b011;
    step("exp.grant");
    chk("exp.owner", 32'(bus.grant), 32'b010);
    repeat (7) step("exp.dwell");
    bus.req = 3'b001;
    step("exp.drop");
    chk("exp.idle0", 32'(bus.grant), 32'd0);
    step("exp.next");
    chk("exp.src0", 32'(bus.grant), 32'b001);

    // Random traffic: sticky request levels, occasional blink/pattern changes.
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(9) == 0) bus.req[k] = ~bus.req[k];
      end
      if ($urandom_range(15) == 0) bus.blink = 3'($urandom);
      if ($urandom_range(3) == 0) bus.pat0 = 16'($urandom);
      if ($urandom_range(3) == 0) bus.pat1 = 16'($urandom);
      if ($urandom_range(3) == 0) bus.pat2 = 16'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
